serial_word_rx: RTL and testbench

//  Receive-side companion to the serial shift-out path. Samples a framed serial

---
 rtl/serial_word_rx.sv | 106 ++++++++++
 tb/tb_serial_word_rx.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serial_word_rx.sv
// rtl/serial_word_rx.sv - framed serial receiver: start bit, WIDTH data bits, stop bit, valid/ready word out
module serial_word_rx #(
    parameter int WIDTH     = 8,
    parameter bit LSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_en,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overrun
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        DATA = 2'd1,
        STOP = 2'd2
    } state_t;

    state_t           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] sreg;
    logic [WIDTH-1:0] sreg_next;
    logic             load;
    logic             accept;

    // LSB-first shifts in from the top so the first bit ends up in bit 0
    always_comb begin
        sreg_next = sreg;
        if (LSB_FIRST) begin
            sreg_next = {sin, sreg[WIDTH-1:1]};
        end else begin
            sreg_next = {sreg[WIDTH-2:0], sin};
        end
    end

    assign load   = sin_en && (state == STOP) && sin;
    assign accept = dout_valid && dout_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            cnt        <= '0;
            sreg       <= '0;
            dout       <= '0;
            dout_valid <= 1'b0;
            busy       <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            if (sin_en) begin
                case (state)
                    IDLE: begin
                        if (!sin) begin
                            state <= DATA;
                            busy  <= 1'b1;
                            cnt   <= '0;
                        end
                    end
                    DATA: begin
                        sreg <= sreg_next;
                        if (cnt == LAST_BIT) begin
                            state <= STOP;
                            cnt   <= '0;
                        end else begin
                            cnt <= cnt + CW'(1);
                        end
                    end
                    STOP: begin
                        // a low stop bit is not treated as the next start bit
                        state <= IDLE;
                        busy  <= 1'b0;
                        if (!sin) begin
                            frame_err <= 1'b1;
                        end
                    end
                    default: begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        cnt   <= '0;
                    end
                endcase
            end

            // a new word may replace the held one only if it is free or being taken now
            if (load) begin
                if (!dout_valid || accept) begin
                    dout       <= sreg;
                    dout_valid <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (accept) begin
                dout_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_rx.sv
// tb/tb_serial_word_rx.sv - scoreboard bench for serial_word_rx (LSB-first and MSB-first instances)
module tb_serial_word_rx;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       sin = 1'b1;
    logic       en_a = 1'b0;
    logic       en_b = 1'b0;
    logic       ready_a = 1'b0;
    logic       ready_b = 1'b1;
    logic [7:0] dout_a, dout_b;
    logic       valid_a, valid_b, busy_a, busy_b, ferr_a, ferr_b, ovr_a, ovr_b;

    int         total = 0;
    int         bad = 0;
    logic [7:0] exp_a[$];
    logic [7:0] exp_b[$];
    bit         seen_a = 1'b0;
    bit         seen_b = 1'b0;

    serial_word_rx #(.WIDTH(8), .LSB_FIRST(1'b1)) dut_a (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(en_a),
        .dout(dout_a), .dout_valid(valid_a), .dout_ready(ready_a),
        .busy(busy_a), .frame_err(ferr_a), .overrun(ovr_a)
    );

    serial_word_rx #(.WIDTH(8), .LSB_FIRST(1'b0)) dut_b (
        .clk(clk), .rst(rst), .sin(sin), .sin_en(en_b),
        .dout(dout_b), .dout_valid(valid_b), .dout_ready(ready_b),
        .busy(busy_b), .frame_err(ferr_b), .overrun(ovr_b)
    );

    initial forever #5 clk = ~clk;

    // a word is checked once when first presented; an accept frees the slot for the next one
    always @(negedge clk) begin
        if (!rst) begin
            seen_a = 1'b0;
        end else begin
            if (valid_a && !seen_a) begin
                total++;
                if (exp_a.size() == 0) begin
                    bad++;
                    $display("FAIL mon_a unexpected word got=%h", dout_a);
                end else begin
                    logic [7:0] e;
                    e = exp_a.pop_front();
                    if (dout_a !== e) begin
                        bad++;
                        $display("FAIL mon_a dout got=%h exp=%h", dout_a, e);
                    end
                end
                seen_a = 1'b1;
            end
            if (valid_a && ready_a) seen_a = 1'b0;
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            seen_b = 1'b0;
        end else begin
            if (valid_b && !seen_b) begin
                total++;
                if (exp_b.size() == 0) begin
                    bad++;
                    $display("FAIL mon_b unexpected word got=%h", dout_b);
                end else begin
                    logic [7:0] e;
                    e = exp_b.pop_front();
                    if (dout_b !== e) begin
                        bad++;
                        $display("FAIL mon_b dout got=%h exp=%h", dout_b, e);
                    end
                end
                seen_b = 1'b1;
            end
            if (valid_b && ready_b) seen_b = 1'b0;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // one bit on the line for per cycles; the strobe is high only on the first
    task automatic send_bit(input logic b, input int per, input bit sel_b);
        sin = b;
        for (int i = 0; i < per; i++) begin
            en_a = (i == 0) && !sel_b;
            en_b = (i == 0) && sel_b;
            tick();
        end
        en_a = 1'b0;
        en_b = 1'b0;
    endtask

    task automatic send_head(input logic [7:0] w, input int nbits, input int per, input bit sel_b);
        send_bit(1'b0, per, sel_b);
        for (int i = 0; i < nbits; i++) begin
            send_bit(sel_b ? w[7-i] : w[i], per, sel_b);
        end
    endtask

    task automatic send_stop(input logic b, input int per, input bit sel_b);
        send_bit(b, per, sel_b);
        sin = 1'b1;
    endtask

    task automatic send_frame(input logic [7:0] w, input int per, input bit sel_b);
        send_head(w, 8, per, sel_b);
        send_stop(1'b1, per, sel_b);
        tick();
        tick();
    endtask

    task automatic do_reset();
        rst = 1'b0;
        sin = 1'b0;
        tick();
        sin = 1'b1;
        tick();
        rst = 1'b1;
        tick();
    endtask

    initial begin
        // 1 reset with the line toggling
        rst = 1'b0;
        sin = 1'b0;
        en_a = 1'b1;
        tick();
        sin = 1'b1;
        tick();
        en_a = 1'b0;
        check("rst_dout", {24'd0, dout_a}, 32'd0);
        check("rst_valid", {31'd0, valid_a}, 32'd0);
        check("rst_busy", {31'd0, busy_a}, 32'd0);
        check("rst_flags", {30'd0, ferr_a, ovr_a}, 32'd0);
        rst = 1'b1;
        tick();
        check("post_rst_busy", {31'd0, busy_a}, 32'd0);

        // 2 basic frame A5, hold ready low then accept
        ready_a = 1'b0;
        exp_a.push_back(8'hA5);
        send_head(8'hA5, 8, 1, 1'b0);
        check("basic_busy", {31'd0, busy_a}, 32'd1);
        check("basic_valid_early", {31'd0, valid_a}, 32'd0);
        send_stop(1'b1, 1, 1'b0);
        check("basic_valid", {31'd0, valid_a}, 32'd1);
        check("basic_busy_done", {31'd0, busy_a}, 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("basic_hold", {24'd0, dout_a}, 32'h0000_00A5);
        end
        ready_a = 1'b1;
        tick();
        check("basic_accept", {31'd0, valid_a}, 32'd0);
        check("basic_dout_kept", {24'd0, dout_a}, 32'h0000_00A5);

        // 3 strobed sampling; a low line without strobe must not start a frame
        sin = 1'b0;
        tick();
        tick();
        tick();
        check("no_strobe_idle", {31'd0, busy_a}, 32'd0);
        sin = 1'b1;
        tick();
        exp_a.push_back(8'h3C);
        send_frame(8'h3C, 4, 1'b0);

        // 4 framing error then a good frame
        send_head(8'hFF, 8, 1, 1'b0);
        send_stop(1'b0, 1, 1'b0);
        tick();
        check("ferr_set", {31'd0, ferr_a}, 32'd1);
        check("ferr_no_valid", {31'd0, valid_a}, 32'd0);
        exp_a.push_back(8'h12);
        send_frame(8'h12, 1, 1'b0);
        check("ferr_sticky", {31'd0, ferr_a}, 32'd1);

        // 5a overrun: second word dropped
        do_reset();
        ready_a = 1'b0;
        exp_a.push_back(8'h11);
        send_frame(8'h11, 1, 1'b0);
        send_frame(8'h22, 1, 1'b0);
        check("ovr_set", {31'd0, ovr_a}, 32'd1);
        check("ovr_dout", {24'd0, dout_a}, 32'h0000_0011);
        ready_a = 1'b1;
        tick();
        check("ovr_drain", {31'd0, valid_a}, 32'd0);

        // 5b load and accept on the same edge
        do_reset();
        ready_a = 1'b0;
        exp_a.push_back(8'h33);
        send_frame(8'h33, 1, 1'b0);
        exp_a.push_back(8'h44);
        send_head(8'h44, 8, 1, 1'b0);
        ready_a = 1'b1;
        send_stop(1'b1, 1, 1'b0);
        ready_a = 1'b0;
        check("simul_dout", {24'd0, dout_a}, 32'h0000_0044);
        check("simul_valid", {31'd0, valid_a}, 32'd1);
        check("simul_ovr", {31'd0, ovr_a}, 32'd0);
        ready_a = 1'b1;
        tick();
        tick();

        // 6 reset mid-frame, LSB-first then MSB-first
        send_head(8'h5A, 4, 1, 1'b0);
        check("mid_busy_pre", {31'd0, busy_a}, 32'd1);
        do_reset();
        check("mid_busy", {31'd0, busy_a}, 32'd0);
        check("mid_valid", {31'd0, valid_a}, 32'd0);
        exp_a.push_back(8'h5A);
        send_frame(8'h5A, 1, 1'b0);

        send_head(8'h5A, 4, 1, 1'b1);
        check("mid_b_busy_pre", {31'd0, busy_b}, 32'd1);
        do_reset();
        check("mid_b_busy", {31'd0, busy_b}, 32'd0);
        check("mid_b_valid", {31'd0, valid_b}, 32'd0);
        exp_b.push_back(8'h5A);
        send_frame(8'h5A, 1, 1'b1);
        exp_b.push_back(8'hC3);
        send_frame(8'hC3, 2, 1'b1);

        tick();
        tick();
        check("sb_a_empty", exp_a.size(), 32'd0);
        check("sb_b_empty", exp_b.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
